// File: rtl/keypad_scanner_if.sv
// Key event handshake between the keypad scanner (master) and its consumer (slave).
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       key_overflow;

  modport master (
    output key_code, key_valid, key_held, key_overflow,
    input  key_ready
  );

  modport slave (
    input  key_code, key_valid, key_held, key_overflow,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, synchronized column sense, debounce FSM and one-entry event register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
//
// state      | meaning
// ST_IDLE    | no key seen on the last scan
// ST_CONFIRM | candidate key seen on consecutive scans, not yet debounced
// ST_HELD    | key confirmed and reported; counting no-hit scans toward release
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic              clk_in,
  input  logic              rst_n,
  output logic [3:0]        keypad_rows,
  input  logic [3:0]        keypad_cols,
  keypad_scanner_if.master  evt
);

  localparam int DW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 4) begin : g_bad_div
    $error("keypad_scanner: SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
    $error("keypad_scanner: DEBOUNCE_SCANS must be 1..15");
  end
  if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_rpt
    $error("keypad_scanner: REPEAT_SCANS must be 1..255");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD} state_t;

  logic [3:0]    cols_s1_q, cols_s2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    row_q;
  logic          dwell_end;
  logic          row_hit;
  logic [1:0]    row_col;
  logic          acc_hit_q;
  logic [3:0]    acc_code_q;
  logic          scan_done_q, scan_hit_q;
  logic [3:0]    scan_code_q;

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          emit;
  logic [3:0]    emit_code;
`ifdef KEYPAD_REPEAT_EN
  logic [7:0]    rpt_q, rpt_d;
`endif

  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cols_s1_q <= '0;
      cols_s2_q <= '0;
    end else begin
      cols_s1_q <= keypad_cols;
      cols_s2_q <= cols_s1_q;
    end
  end

  assign dwell_end   = (dwell_q == DW'(SCAN_DIV - 1));
  assign keypad_rows = 4'b0001 << row_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      row_q   <= '0;
    end else if (dwell_end) begin
      dwell_q <= '0;
      row_q   <= row_q + 2'd1;
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  assign row_hit = |cols_s2_q;

  always_comb begin
    row_col = 2'd0;
    if      (cols_s2_q[0]) row_col = 2'd0;
    else if (cols_s2_q[1]) row_col = 2'd1;
    else if (cols_s2_q[2]) row_col = 2'd2;
    else if (cols_s2_q[3]) row_col = 2'd3;
  end

  // Earlier rows win, so a row only lands in the accumulator if nothing was found yet.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc_hit_q   <= 1'b0;
      acc_code_q  <= '0;
      scan_done_q <= 1'b0;
      scan_hit_q  <= 1'b0;
      scan_code_q <= '0;
    end else begin
      scan_done_q <= 1'b0;
      if (dwell_end) begin
        if (row_q == 2'd3) begin
          scan_done_q <= 1'b1;
          scan_hit_q  <= acc_hit_q | row_hit;
          scan_code_q <= acc_hit_q ? acc_code_q : {row_q, row_col};
          acc_hit_q   <= 1'b0;
          acc_code_q  <= '0;
        end else if (!acc_hit_q && row_hit) begin
          acc_hit_q  <= 1'b1;
          acc_code_q <= {row_q, row_col};
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_code = cand_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d     = rpt_q;
`endif
    if (scan_done_q) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_hit_q) begin
            cand_d    = scan_code_q;
            emit_code = scan_code_q;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = ST_HELD;
              emit    = 1'b1;
              cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              state_d = ST_CONFIRM;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_CONFIRM: begin
          if (!scan_hit_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (scan_code_q == cand_q) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              state_d = ST_HELD;
              emit    = 1'b1;
              cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cand_d = scan_code_q;
            cnt_d  = 4'd1;
          end
        end
        ST_HELD: begin
          if (!scan_hit_q) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            // Only scans that still see a key advance the repeat timer, so a release never repeats.
            if (rpt_q + 8'd1 == 8'(REPEAT_SCANS)) begin
              emit  = 1'b1;
              rpt_d = '0;
            end else begin
              rpt_d = rpt_q + 8'd1;
            end
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign accept = valid_q & evt.key_ready;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    if (emit) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        code_d  = emit_code;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt.key_valid    = valid_q;
  assign evt.key_code     = code_q;
  assign evt.key_overflow = ovf_q;
  assign evt.key_held     = (state_q == ST_HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=4, REPEAT_SCANS=2 (16 cycles per scan).
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int SCAN = 4 * SD;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [3:0]  keypad_rows;
  logic [3:0]  keypad_cols;
  logic [15:0] key_mask;
  int          cyc;
  int          n_cmp  = 0;
  int          n_fail = 0;

  typedef struct { int cyc; int code; } ev_t;
  ev_t evq[$];
  int  ovfq[$];
  logic prev_valid;

  typedef struct { logic [15:0] mask; int code; } vec_t;
  vec_t vecs[7];

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(4), .REPEAT_SCANS(2)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .keypad_rows (keypad_rows),
    .keypad_cols (keypad_cols),
    .evt         (kif.master)
  );

  always #5 clk_in = ~clk_in;

  always_comb begin
    keypad_cols = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (keypad_rows[r]) keypad_cols = keypad_cols | key_mask[r*4 +: 4];
  end

  always @(posedge clk_in or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (kif.key_valid && !prev_valid) evq.push_back('{cyc, int'(kif.key_code)});
      if (kif.key_overflow) ovfq.push_back(cyc);
      prev_valid = kif.key_valid;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ev_code(input int i);
    return (i < evq.size()) ? evq[i].code : -1;
  endfunction

  function automatic int ev_cyc(input int i);
    return (i < evq.size()) ? evq[i].cyc : -1;
  endfunction

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    key_mask = '0;
    kif.key_ready = rdy;
    repeat (3) @(negedge clk_in);
    evq.delete();
    ovfq.delete();
    rst_n = 1'b1;
  endtask

  task automatic run_scans(input logic [15:0] m, input int n);
    key_mask = m;
    repeat (SCAN * n) @(negedge clk_in);
  endtask

  initial begin
    vecs[0] = '{16'h0040, 6};
    vecs[1] = '{16'h0001, 0};
    vecs[2] = '{16'h8000, 15};
    vecs[3] = '{16'h8300, 8};
    vecs[4] = '{16'h0018, 3};
    vecs[5] = '{16'h00C0, 6};
    vecs[6] = '{16'h4000, 14};

    rst_n = 1'b0;
    key_mask = '0;
    kif.key_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_rows",  int'(keypad_rows), 1);
    check("rst_valid", int'(kif.key_valid), 0);
    check("rst_code",  int'(kif.key_code), 0);
    check("rst_held",  int'(kif.key_held), 0);
    check("rst_ovf",   int'(kif.key_overflow), 0);

    // Row drive sequence
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      check("rows_seq", int'(keypad_rows), 1 << ((i / 4) % 4));
      @(negedge clk_in);
    end

    // Priority table: each mask held long enough to confirm, then released
    foreach (vecs[v]) begin
      do_reset(1'b1);
      run_scans(vecs[v].mask, 5);
      check("tbl_held",   int'(kif.key_held), 1);
      check("tbl_evcnt",  evq.size(), 1);
      check("tbl_code",   ev_code(0), vecs[v].code);
      check("tbl_evtime", ev_cyc(0), 4 * SCAN + 1);
      run_scans(16'h0000, 5);
      check("tbl_release", int'(kif.key_held), 0);
      check("tbl_evcnt2",  evq.size(), 1);
    end

    // Bounce: 2 scans, gap, then the press must need a full fresh debounce
    do_reset(1'b1);
    run_scans(16'h0040, 2);
    run_scans(16'h0000, 1);
    run_scans(16'h0040, 2);
    check("bounce_noev", evq.size(), 0);
    check("bounce_held", int'(kif.key_held), 0);
    run_scans(16'h0040, 3);
    check("bounce_evcnt", evq.size(), 1);
    check("bounce_time",  ev_cyc(0), 7 * SCAN + 1);
    check("bounce_code",  ev_code(0), 6);

    // Overflow with consumer stalled, then accept coinciding with a new event
    do_reset(1'b0);
    run_scans(16'h0001, 4);
    run_scans(16'h0000, 4);
    run_scans(16'h0020, 4);
    run_scans(16'h0000, 4);
    check("ovf_valid",  int'(kif.key_valid), 1);
    check("ovf_code",   int'(kif.key_code), 0);
    check("ovf_count",  ovfq.size(), 1);
    check("ovf_time",   (ovfq.size() > 0) ? ovfq[0] : -1, 12 * SCAN + 1);
    check("ovf_evcnt",  evq.size(), 1);
    run_scans(16'h0200, 3);
    repeat (SCAN) @(negedge clk_in);
    kif.key_ready = 1'b1;
    @(negedge clk_in);
    check("swap_valid", int'(kif.key_valid), 1);
    check("swap_code",  int'(kif.key_code), 9);
    check("swap_ovf",   int'(kif.key_overflow), 0);
    @(negedge clk_in);
    check("swap_clear", int'(kif.key_valid), 0);
    check("swap_ovfcnt", ovfq.size(), 1);

    // Long hold of key 15, then reset asserted mid-scan
    do_reset(1'b1);
    run_scans(16'h8000, 9);
    kif.key_ready = 1'b0;
    repeat (SCAN + 5) @(negedge clk_in);
`ifdef KEYPAD_REPEAT_EN
    check("rpt_evcnt", evq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("rpt_time", ev_cyc(k), (4 + 2 * k) * SCAN + 1);
      check("rpt_code", ev_code(k), 15);
    end
    check("rpt_valid_pre", int'(kif.key_valid), 1);
`else
    check("norpt_evcnt", evq.size(), 1);
    check("norpt_time",  ev_cyc(0), 4 * SCAN + 1);
    check("norpt_code",  ev_code(0), 15);
    check("norpt_valid_pre", int'(kif.key_valid), 0);
`endif
    check("hold_held", int'(kif.key_held), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rows",  int'(keypad_rows), 1);
    check("midrst_valid", int'(kif.key_valid), 0);
    check("midrst_held",  int'(kif.key_held), 0);
    check("midrst_code",  int'(kif.key_code), 0);

    // Restart at row 0 after reset release
    do_reset(1'b1);
    repeat (3) @(negedge clk_in);
    check("restart_row0", int'(keypad_rows), 1);
    @(negedge clk_in);
    check("restart_row1", int'(keypad_rows), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk_in cycles each row is driven (dwell); legal values 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive full scans needed to confirm a press or a release; legal range 1..15.
REQ-003 SHALL have parameter REPEAT_SCANS, default 64, meaning full scans between auto-repeat events; legal range 1..255.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port keypad_rows, output, 4 bits: one-hot active-high row drive.
REQ-007 SHALL have port keypad_cols, input, 4 bits: asynchronous active-high column sense.
REQ-008 SHALL have port key_code, output, 4 bits: code of the reported key, row*4+col.
REQ-009 SHALL have port key_valid, output, 1 bit: key_code holds an unconsumed event.
REQ-010 SHALL have port key_ready, input, 1 bit: consumer accepts the event.
REQ-011 SHALL have port key_held, output, 1 bit: high while the FSM is in HELD.
REQ-012 SHALL have port key_overflow, output, 1 bit: one-cycle pulse when an event is dropped.

Function
REQ-013 SHALL pass keypad_cols through a 2-flop synchronizer before any use.
REQ-014 SHALL count dwell cycles 0..SCAN_DIV-1; at SCAN_DIV-1 the row index SHALL advance 0->1->2->3->0, wrapping after 3, and keypad_rows SHALL equal 1<<row index.
REQ-015 SHALL sample the synchronized columns only in dwell cycle SCAN_DIV-1 of each row.
REQ-016 Per scan (rows 0..3), the first hit SHALL win: lowest row, then lowest column within that row; scan result = {hit, code}.
REQ-017 The FSM SHALL evaluate once per completed scan, in the cycle after row 3 is sampled.
REQ-018 The FSM SHALL have three states: IDLE, CONFIRM and HELD.
REQ-019 In IDLE, a hit SHALL latch the code as the candidate, set the count to 1 and enter CONFIRM; if DEBOUNCE_SCANS=1 it SHALL go directly to HELD and emit an event.
REQ-020 In CONFIRM, a hit with the same code SHALL increment the count; reaching DEBOUNCE_SCANS SHALL emit the candidate and enter HELD.
REQ-021 In CONFIRM, a hit with a different code SHALL restart CONFIRM with the new candidate and count 1.
REQ-022 In CONFIRM, no hit SHALL return the FSM to IDLE.
REQ-023 In HELD, a scan with no hit SHALL increment the release count; reaching DEBOUNCE_SCANS SHALL enter IDLE.
REQ-024 In HELD, any hit SHALL clear the release count; a different key in HELD SHALL NOT emit an event.
REQ-025 Emission SHALL load a one-entry register: key_valid rises in the cycle after the FSM evaluation and is held with key_code stable until a cycle with key_valid and key_ready both high.
REQ-026 If an event is emitted while key_valid=1 and key_ready=0, the new event SHALL be dropped, the register unchanged, and key_overflow pulsed for 1 cycle.
REQ-027 If an event is emitted in the same cycle the current event is accepted, the new event SHALL load and key_valid SHALL stay high.
REQ-028 key_ready while key_valid=0 SHALL have no effect.

Reset
REQ-029 On rst_n low, immediately and regardless of clock, the block SHALL set: keypad_rows=4'b0001, row index 0, dwell and all scan counters 0, synchronizer flops 0, FSM state IDLE.
REQ-030 On rst_n low, the block SHALL set key_code=0, key_valid=0, key_held=0 and key_overflow=0; an unconsumed event SHALL be discarded.
REQ-031 Reset deassertion mid-scan SHALL restart scanning at row 0 with dwell count 0.

Configuration
REQ-032 With macro KEYPAD_REPEAT_EN defined, HELD SHALL count full scans and emit the held code every REPEAT_SCANS scans; the counter SHALL clear when HELD is entered and on each emission.
REQ-033 With KEYPAD_REPEAT_EN undefined, the repeat logic SHALL be absent, and exactly one event SHALL be emitted per confirmed press.

Verification
REQ-034 Bench (SCAN_DIV=4, DEBOUNCE_SCANS=4), reset then run 20 cycles -> keypad_rows sequence 0001,0010,0100,1000,0001, each value held 4 cycles.
REQ-035 Bench (same settings), keypad_cols=0100 only while row 1 is driven, held 4 scans, key_ready=1 -> one key_valid pulse with key_code=6, then key_held=1.
REQ-036 Bench (same settings), key 6 held 2 scans, released 1 scan, held 2 scans -> no event emitted and FSM back in CONFIRM.
REQ-037 Bench (same settings), press key 0 then key 5 (each confirmed, released) with key_ready=0 -> key_code stays 0, key_overflow pulses once, and raising key_ready clears key_valid.
REQ-038 Bench (same settings), columns 0011 on row 2 together with column 1000 on row 3 -> reported key_code=8.
REQ-039 Bench with KEYPAD_REPEAT_EN defined and REPEAT_SCANS=2, key 15 held 10 scans -> events at scans 4, 6, 8 and 10, all code 15; assert rst_n mid-scan -> rows=0001 and key_valid=0 at once.
